qed_pair_scan_checker: RTL and testbench
========================================

// Module: qed_pair_scan_checker
// PURPOSE
// - Parametrised QED self-consistency checker for the vscale QED pipeline.
// - Counts committed original and duplicate instructions.
// - Once both streams have committed the same number of instructions, scans
//   every register pair (reg[j], reg[j+NREGS/2]), LANES pairs per cycle.
// - Reports pass or fail pulses, plus a sticky mismatch flag and the index of
//   the first mismatching pair.
// - Sits beside the pipeline: inputs are the register-file taps and the
//   commit strobes; outputs drive formal assertions and sim monitors.
// PARAMETERS
// - XLEN          32  register width in bits
// - NREGS         32  total architectural registers; lower half original, upper half duplicate; even
// - LANES          4  register pairs compared per scan cycle; must divide NREGS/2
// - SETTLE_CYCLES  2  idle cycles between counts matching and scan start; 0 = start next cycle
// - CNT_W          8  width of the commit counters
// - SKIP_ZERO      1  1: pair 0 always treated as matching (x0/x16 hardwired)
// PORTS
// - clk          in   1               rising-edge clock
// - rst          in   1               synchronous, active-low reset (0 = reset)
// - chk_en       in   1               checking allowed this cycle
// - orig_commit  in   1               one original instruction committed this cycle
// - dup_commit   in   1               one duplicate instruction committed this cycle
// - regs_flat    in   NREGS*XLEN      register file; reg[k] = regs_flat[k*XLEN +: XLEN]
// - busy         out  1               FSM in SETTLE or SCAN
// - check_pass   out  1               1-cycle pulse: full scan done, no mismatch
// - check_fail   out  1               1-cycle pulse: mismatch found
// - mismatch     out  1               sticky; set by any fail, cleared only by reset
// - mismatch_idx out  $clog2(NREGS/2) pair index of the first fail since reset
// - orig_count   out  CNT_W           committed original instructions, saturating
// - dup_count    out  CNT_W           committed duplicate instructions, saturating
// BEHAVIOUR
// - Reset (rst==0 at posedge): state=IDLE; all outputs, counters and the
//   dirty flag = 0. This holds in any state, including mid-scan.
// - Counters:
//   - Each strobe increments its own counter.
//   - Both strobes may assert in the same cycle; each counter increments once.
//   - A counter saturates at 2^CNT_W-1 and never wraps.
//   - Any strobe sets the dirty flag.
// - FSM states and transitions:
//   - IDLE -> SETTLE when chk_en && dirty && orig_count==dup_count
//     && orig_count!=0 && !orig_commit && !dup_commit. Dirty clears on this
//     transition and the settle counter loads SETTLE_CYCLES.
//   - With SETTLE_CYCLES=0, IDLE -> SCAN directly instead.
//   - SETTLE: decrement the settle counter; at 0 -> SCAN with scan pointer p=0.
//   - SCAN: each cycle compare pairs p*LANES .. p*LANES+LANES-1 combinationally
//     from the live regs_flat; then p++.
//   - Scan length is NREGS/(2*LANES) cycles.
//   - Any mismatch in a SCAN cycle -> FAIL handling (below).
//   - Last group clean -> check_pass=1 for one cycle, state -> IDLE.
// - Abort: orig_commit, dup_commit or !chk_en during SETTLE or SCAN -> IDLE.
//   No pass or fail pulse is issued. Dirty is re-set by the strobe; chk_en
//   drop alone leaves dirty cleared.
// - Fail:
//   - check_fail pulses for one cycle and mismatch is set.
//   - If mismatch was 0, mismatch_idx = lowest failing pair in that group.
//     Later fails never update it.
// - Latency: counts matching -> check_pass is SETTLE_CYCLES + NREGS/(2*LANES)
//   + 1 cycles.
// - check_pass and check_fail are never both 1 in the same cycle.
// - busy is 1 exactly in SETTLE and SCAN.
// CONFIGURATION
// - QED_CHK_STOP_ON_FAIL_EN defined:
//   - A fail moves the FSM to a terminal HALT state until reset.
//   - In HALT: busy=0, no further pulses; the counters keep counting.
// - QED_CHK_STOP_ON_FAIL_EN undefined:
//   - A fail returns the FSM to IDLE.
//   - Checking resumes on the next dirty count match; mismatch stays sticky.
// TESTING
// - Defaults. Assert rst=0 for 2 cycles in mid-SCAN -> next cycle state IDLE,
//   all outputs and counters 0.
// - 3 orig then 3 dup commits, regs[j]==regs[j+16] for all j
//   -> check_pass exactly 2+4+1=7 cycles after the 3rd dup commit.
//   No check_fail; mismatch=0.
// - Same stimulus, reg[5]=0x1234 and reg[21]=0x1235 -> check_fail during the
//   scan group covering pair 5; mismatch=1; mismatch_idx=5.
// - Counts equal at 2/2, dup_commit pulses during the 2nd SCAN cycle
//   -> abort, no pulse. After the matching orig commit, a new scan starts
//   and passes.
// - CNT_W=4: 20 orig and 20 dup commits -> both counters stay at 15, a check
//   runs, check_pass.
// - QED_CHK_STOP_ON_FAIL_EN: after a fail, a further dirty match -> busy stays 0,
//   no further pulses; without the macro a second check runs.

Source files
------------

// File: rtl/qed_pair_scan_checker.sv
// ---------------------------------------------------------------------------
// qed_pair_scan_checker
//
// QED self-consistency checker for the vscale QED pipeline. Counts committed
// original and duplicate instructions; once both streams have committed the
// same (non-zero) number and are quiet, it waits SETTLE_CYCLES and then scans
// every register pair (reg[j], reg[j+NREGS/2]), LANES pairs per cycle, from
// the live register-file taps. A clean full scan pulses check_pass; a
// mismatching group pulses check_fail and sets the sticky mismatch flag.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-low reset (0 = reset)
//   chk_en       in   checking allowed this cycle
//   orig_commit  in   one original instruction committed this cycle
//   dup_commit   in   one duplicate instruction committed this cycle
//   regs_flat    in   register file, reg[k] = regs_flat[k*XLEN +: XLEN]
//   busy         out  FSM in SETTLE or SCAN
//   check_pass   out  1-cycle pulse: full scan finished clean
//   check_fail   out  1-cycle pulse: mismatch found in a scan group
//   mismatch     out  sticky mismatch flag, cleared only by reset
//   mismatch_idx out  pair index of the first failing pair since reset
//   orig_count   out  saturating count of original commits
//   dup_count    out  saturating count of duplicate commits
//
// Configuration macro: QED_CHK_STOP_ON_FAIL_EN
//   defined   : a fail parks the FSM in a terminal HALT state until reset
//   undefined : a fail returns to IDLE and checking resumes on the next match
// ---------------------------------------------------------------------------
module qed_pair_scan_checker #(
  parameter int XLEN          = 32,
  parameter int NREGS         = 32,
  parameter int LANES         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8,
  parameter int SKIP_ZERO     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        chk_en,
  input  logic                        orig_commit,
  input  logic                        dup_commit,
  input  logic [NREGS*XLEN-1:0]       regs_flat,
  output logic                        busy,
  output logic                        check_pass,
  output logic                        check_fail,
  output logic                        mismatch,
  output logic [$clog2(NREGS/2)-1:0]  mismatch_idx,
  output logic [CNT_W-1:0]            orig_count,
  output logic [CNT_W-1:0]            dup_count
);

  localparam int HALF    = NREGS / 2;
  localparam int NGROUPS = HALF / LANES;
  localparam int PTR_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam int IDX_W   = $clog2(HALF);
  localparam int SET_W   = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SCAN   = 2'd2,
    HALT   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               dirty_q, dirty_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic               mismatch_q, mismatch_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   orig_q, orig_d;
  logic [CNT_W-1:0]   dup_q, dup_d;

  logic [LANES-1:0]   lane_fail;
  logic               grp_fail;
  logic [IDX_W-1:0]   fail_idx;
  logic               strobe;
  logic               abort;
  logic               start;

  // Group compare straight from the live register taps. Pair 0 may be
  // excluded because x0 and its duplicate are hardwired and never diverge.
  always_comb begin
    int pair;
    pair      = 0;
    lane_fail = '0;
    for (int l = 0; l < LANES; l++) begin
      pair = int'(ptr_q) * LANES + l;
      lane_fail[l] = (regs_flat[pair*XLEN +: XLEN] != regs_flat[(pair+HALF)*XLEN +: XLEN])
                     && !((SKIP_ZERO != 0) && (pair == 0));
    end
  end

  // Lowest failing lane wins: walk from the top lane down so the last
  // assignment is the smallest index.
  always_comb begin
    fail_idx = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (lane_fail[l]) fail_idx = IDX_W'(int'(ptr_q) * LANES + l);
    end
    grp_fail = |lane_fail;
  end

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    ptr_d      = ptr_q;
    dirty_d    = dirty_q;
    pass_d     = 1'b0;
    fail_d     = 1'b0;
    mismatch_d = mismatch_q;
    idx_d      = idx_q;
    orig_d     = orig_q;
    dup_d      = dup_q;

    strobe = orig_commit | dup_commit;
    abort  = strobe | ~chk_en;
    start  = chk_en && dirty_q && (orig_q == dup_q) && (orig_q != '0) && !strobe;

    if (orig_commit && (orig_q != '1)) orig_d = orig_q + CNT_W'(1);
    if (dup_commit  && (dup_q  != '1)) dup_d  = dup_q  + CNT_W'(1);
    if (strobe) dirty_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          dirty_d = 1'b0;
          ptr_d   = '0;
          if (SETTLE_CYCLES == 0) begin
            state_d = SCAN;
          end else begin
            state_d  = SETTLE;
            settle_d = SET_W'(SETTLE_CYCLES);
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          settle_d = settle_q - SET_W'(1);
          if (settle_q == SET_W'(1)) begin
            state_d = SCAN;
            ptr_d   = '0;
          end
        end
      end
      SCAN: begin
        // A commit or enable drop invalidates the snapshot: leave silently.
        if (abort) begin
          state_d = IDLE;
        end else if (grp_fail) begin
          fail_d     = 1'b1;
          mismatch_d = 1'b1;
          if (!mismatch_q) idx_d = fail_idx;
`ifdef QED_CHK_STOP_ON_FAIL_EN
          state_d = HALT;
`else
          state_d = IDLE;
`endif
        end else if (ptr_q == PTR_W'(NGROUPS - 1)) begin
          pass_d  = 1'b1;
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      ptr_q      <= '0;
      dirty_q    <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      mismatch_q <= 1'b0;
      idx_q      <= '0;
      orig_q     <= '0;
      dup_q      <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      ptr_q      <= ptr_d;
      dirty_q    <= dirty_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      mismatch_q <= mismatch_d;
      idx_q      <= idx_d;
      orig_q     <= orig_d;
      dup_q      <= dup_d;
    end
  end

  assign busy         = (state_q == SETTLE) || (state_q == SCAN);
  assign check_pass   = pass_q;
  assign check_fail   = fail_q;
  assign mismatch     = mismatch_q;
  assign mismatch_idx = idx_q;
  assign orig_count   = orig_q;
  assign dup_count    = dup_q;

endmodule

// File: tb/tb_qed_pair_scan_checker.sv
module tb_qed_pair_scan_checker;

  logic          clk;
  logic          rst;
  logic          chk_en;
  logic          orig_commit;
  logic          dup_commit;
  logic [1023:0] regs_flat;

  logic          busy, check_pass, check_fail, mismatch;
  logic [3:0]    mismatch_idx;
  logic [7:0]    orig_count, dup_count;

  logic          busy4, pass4, fail4, mismatch4;
  logic [3:0]    idx4;
  logic [3:0]    oc4, dc4;

  int total;
  int bad;

  qed_pair_scan_checker dut (
    .clk(clk), .rst(rst), .chk_en(chk_en), .orig_commit(orig_commit),
    .dup_commit(dup_commit), .regs_flat(regs_flat), .busy(busy),
    .check_pass(check_pass), .check_fail(check_fail), .mismatch(mismatch),
    .mismatch_idx(mismatch_idx), .orig_count(orig_count), .dup_count(dup_count)
  );

  qed_pair_scan_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .chk_en(chk_en), .orig_commit(orig_commit),
    .dup_commit(dup_commit), .regs_flat(regs_flat), .busy(busy4),
    .check_pass(pass4), .check_fail(fail4), .mismatch(mismatch4),
    .mismatch_idx(idx4), .orig_count(oc4), .dup_count(dc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic o, input logic d);
    orig_commit = o;
    dup_commit  = d;
    step();
    orig_commit = 1'b0;
    dup_commit  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; orig_commit = 1'b0; dup_commit = 1'b0; chk_en = 1'b1;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic set_regs_equal();
    logic [31:0] v;
    for (int j = 0; j < 16; j++) begin
      v = 32'hA500_0000 | (j * 32'h0000_0101);
      regs_flat[j*32 +: 32]      = v;
      regs_flat[(j+16)*32 +: 32] = v;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({busy, check_pass, check_fail, mismatch, mismatch_idx, orig_count, dup_count} !== 23'd0) begin
      bad++;
      $display("FAIL reset_init: got busy=%b pass=%b fail=%b mm=%b idx=%0d oc=%0d dc=%0d want all 0",
               busy, check_pass, check_fail, mismatch, mismatch_idx, orig_count, dup_count);
    end
  endtask

  task automatic test_pass();
    logic exp;
    do_reset();
    set_regs_equal();
    for (int k = 0; k < 3; k++) commit(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) commit(1'b0, 1'b1);
    for (int i = 1; i <= 7; i++) begin
      step();
      exp = (i == 7);
      total++;
      if (check_pass !== exp) begin
        bad++; $display("FAIL pass_pulse c%0d: got %b want %b", i, check_pass, exp);
      end
      total++;
      if (check_fail !== 1'b0) begin
        bad++; $display("FAIL pass_nofail c%0d: got %b want 0", i, check_fail);
      end
      exp = (i <= 6);
      total++;
      if (busy !== exp) begin
        bad++; $display("FAIL pass_busy c%0d: got %b want %b", i, busy, exp);
      end
    end
    total++;
    if (mismatch !== 1'b0) begin
      bad++; $display("FAIL pass_mismatch: got %b want 0", mismatch);
    end
  endtask

  task automatic test_fail();
    logic exp;
    do_reset();
    set_regs_equal();
    regs_flat[5*32 +: 32]  = 32'h0000_1234;
    regs_flat[21*32 +: 32] = 32'h0000_1235;
    for (int k = 0; k < 3; k++) commit(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) commit(1'b0, 1'b1);
    for (int i = 1; i <= 7; i++) begin
      step();
      exp = (i == 5);
      total++;
      if (check_fail !== exp) begin
        bad++; $display("FAIL fail_pulse c%0d: got %b want %b", i, check_fail, exp);
      end
      total++;
      if (check_pass !== 1'b0) begin
        bad++; $display("FAIL fail_nopass c%0d: got %b want 0", i, check_pass);
      end
    end
    total++;
    if (mismatch !== 1'b1) begin
      bad++; $display("FAIL fail_mismatch: got %b want 1", mismatch);
    end
    total++;
    if (mismatch_idx !== 4'd5) begin
      bad++; $display("FAIL fail_idx: got %0d want 5", mismatch_idx);
    end
  endtask

  // Continues from test_fail: mismatch is already set at pair 5.
  task automatic test_second_check();
    logic exp;
    regs_flat[21*32 +: 32] = regs_flat[5*32 +: 32];
    regs_flat[10*32 +: 32] = 32'h0000_DEAD;
    regs_flat[26*32 +: 32] = 32'h0000_BEEF;
    commit(1'b1, 1'b0);
    commit(1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step();
`ifdef QED_CHK_STOP_ON_FAIL_EN
      exp = 1'b0;
      total++;
      if (busy !== 1'b0) begin
        bad++; $display("FAIL halt_busy c%0d: got %b want 0", i, busy);
      end
`else
      exp = (i == 6);
      total++;
      if (busy !== (i <= 5)) begin
        bad++; $display("FAIL second_busy c%0d: got %b want %b", i, busy, (i <= 5));
      end
`endif
      total++;
      if (check_fail !== exp) begin
        bad++; $display("FAIL second_fail c%0d: got %b want %b", i, check_fail, exp);
      end
      total++;
      if (check_pass !== 1'b0) begin
        bad++; $display("FAIL second_nopass c%0d: got %b want 0", i, check_pass);
      end
    end
    total++;
    if (mismatch_idx !== 4'd5 || mismatch !== 1'b1) begin
      bad++; $display("FAIL second_sticky: got mm=%b idx=%0d want mm=1 idx=5", mismatch, mismatch_idx);
    end
    total++;
    if (orig_count !== 8'd4 || dup_count !== 8'd4) begin
      bad++; $display("FAIL second_counts: got %0d/%0d want 4/4", orig_count, dup_count);
    end
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    set_regs_equal();
    commit(1'b1, 1'b1);
    total++;
    if (orig_count !== 8'd1 || dup_count !== 8'd1) begin
      bad++; $display("FAIL both_strobe_counts: got %0d/%0d want 1/1", orig_count, dup_count);
    end
    for (int k = 0; k < 4; k++) step();
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL midscan_busy: got %b want 1", busy);
    end
    rst = 1'b0;
    step();
    step();
    total++;
    if ({busy, check_pass, check_fail, mismatch, mismatch_idx, orig_count, dup_count} !== 23'd0) begin
      bad++;
      $display("FAIL reset_midscan: got busy=%b pass=%b fail=%b mm=%b idx=%0d oc=%0d dc=%0d want all 0",
               busy, check_pass, check_fail, mismatch, mismatch_idx, orig_count, dup_count);
    end
    rst = 1'b1;
    for (int k = 0; k < 4; k++) step();
    total++;
    if (busy !== 1'b0 || check_pass !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle: got busy=%b pass=%b want 0 0", busy, check_pass);
    end
  endtask

  task automatic test_abort();
    logic exp;
    do_reset();
    set_regs_equal();
    commit(1'b1, 1'b0);
    commit(1'b0, 1'b1);
    commit(1'b1, 1'b0);
    commit(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step();
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL abort_prebusy: got %b want 1", busy);
    end
    commit(1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (check_pass !== 1'b0 || check_fail !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL abort_quiet c%0d: got pass=%b fail=%b busy=%b want 0 0 0",
                        i, check_pass, check_fail, busy);
      end
      step();
    end
    total++;
    if (dup_count !== 8'd3) begin
      bad++; $display("FAIL abort_dupcount: got %0d want 3", dup_count);
    end
    commit(1'b1, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      step();
      exp = (i == 7);
      total++;
      if (check_pass !== exp) begin
        bad++; $display("FAIL abort_rescan c%0d: got %b want %b", i, check_pass, exp);
      end
    end
  endtask

  task automatic test_saturation();
    logic exp;
    do_reset();
    set_regs_equal();
    for (int k = 0; k < 20; k++) commit(1'b1, 1'b1);
    total++;
    if (oc4 !== 4'd15 || dc4 !== 4'd15) begin
      bad++; $display("FAIL sat4_counts: got %0d/%0d want 15/15", oc4, dc4);
    end
    total++;
    if (orig_count !== 8'd20 || dup_count !== 8'd20) begin
      bad++; $display("FAIL cnt8_counts: got %0d/%0d want 20/20", orig_count, dup_count);
    end
    for (int i = 1; i <= 7; i++) begin
      step();
      exp = (i == 7);
      total++;
      if (pass4 !== exp) begin
        bad++; $display("FAIL sat4_pass c%0d: got %b want %b", i, pass4, exp);
      end
      total++;
      if (check_pass !== exp) begin
        bad++; $display("FAIL cnt8_pass c%0d: got %b want %b", i, check_pass, exp);
      end
    end
    for (int k = 0; k < 240; k++) commit(1'b1, 1'b1);
    total++;
    if (orig_count !== 8'd255 || dup_count !== 8'd255 || oc4 !== 4'd15) begin
      bad++; $display("FAIL sat8_counts: got %0d/%0d/%0d want 255/255/15", orig_count, dup_count, oc4);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    chk_en = 1'b1;
    orig_commit = 1'b0;
    dup_commit = 1'b0;
    regs_flat = '0;
    test_reset();
    test_pass();
    test_fail();
    test_second_check();
    test_reset_mid_scan();
    test_abort();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
